// File: rtl/chain_reader.sv
// chain_reader: walks one packet's linked list in ctrl memory starting at its head
// block. Each data block address is presented downstream in chain order, and each
// block is returned to the allocator after it has been accepted. One packet at a time.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   i_start, i_head_addr, i_pkt_len     packet request from the egress scheduler
//   o_busy                              high whenever the FSM is not idle
//   o_ctrl_addr, i_ctrl_rdata           ctrl memory read port (1-cycle synchronous read)
//   o_blk_valid, i_blk_ready            downstream block handshake
//   o_blk_addr, o_blk_idx, o_blk_last   block payload
//   o_free_en, o_free_addr              block release pulse to the allocator
//   o_done, o_err, o_err_code           completion / error pulses
//                                       (err_code 01 unallocated, 10 length mismatch, 11 bad start)
module chain_reader #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned LEN_W    = 6,
  parameter int unsigned CTRL_W   = 11,
  parameter int unsigned FREE_GAP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_head_addr,
  input  logic [LEN_W-1:0]  i_pkt_len,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_ctrl_addr,
  input  logic [CTRL_W-1:0] i_ctrl_rdata,
  output logic              o_blk_valid,
  input  logic              i_blk_ready,
  output logic [ADDR_W-1:0] o_blk_addr,
  output logic [LEN_W-1:0]  o_blk_idx,
  output logic              o_blk_last,
  output logic              o_free_en,
  output logic [ADDR_W-1:0] o_free_addr,
  output logic              o_done,
  output logic              o_err,
  output logic [1:0]        o_err_code
);

  localparam int unsigned GAP_W = (FREE_GAP > 2) ? $clog2(FREE_GAP - 1) : 1;

  localparam logic [1:0] ERR_UNALLOC  = 2'b01;
  localparam logic [1:0] ERR_MISMATCH = 2'b10;
  localparam logic [1:0] ERR_BADSTART = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WAIT, S_EMIT, S_FREE, S_GAP
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_cur, w_cur_nxt;
  logic [ADDR_W-1:0]  r_next, w_next_nxt;
  logic [LEN_W-1:0]   r_rem, w_rem_nxt;
  logic [LEN_W-1:0]   r_idx, w_idx_nxt;
  logic [GAP_W-1:0]   r_gap, w_gap_nxt;

  logic               w_busy_nxt, w_blk_valid_nxt, w_blk_last_nxt;
  logic [ADDR_W-1:0]  w_ctrl_addr_nxt, w_blk_addr_nxt, w_free_addr_nxt;
  logic [LEN_W-1:0]   w_blk_idx_nxt;
  logic               w_free_en_nxt, w_done_nxt, w_err_nxt;
  logic [1:0]         w_err_code_nxt;

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cur       <= '0;
      r_next      <= '0;
      r_rem       <= '0;
      r_idx       <= '0;
      r_gap       <= '0;
      o_busy      <= 1'b0;
      o_ctrl_addr <= '0;
      o_blk_valid <= 1'b0;
      o_blk_addr  <= '0;
      o_blk_idx   <= '0;
      o_blk_last  <= 1'b0;
      o_free_en   <= 1'b0;
      o_free_addr <= '0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_err_code  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur       <= w_cur_nxt;
      r_next      <= w_next_nxt;
      r_rem       <= w_rem_nxt;
      r_idx       <= w_idx_nxt;
      r_gap       <= w_gap_nxt;
      o_busy      <= w_busy_nxt;
      o_ctrl_addr <= w_ctrl_addr_nxt;
      o_blk_valid <= w_blk_valid_nxt;
      o_blk_addr  <= w_blk_addr_nxt;
      o_blk_idx   <= w_blk_idx_nxt;
      o_blk_last  <= w_blk_last_nxt;
      o_free_en   <= w_free_en_nxt;
      o_free_addr <= w_free_addr_nxt;
      o_done      <= w_done_nxt;
      o_err       <= w_err_nxt;
      o_err_code  <= w_err_code_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_cur_nxt       = r_cur;
    w_next_nxt      = r_next;
    w_rem_nxt       = r_rem;
    w_idx_nxt       = r_idx;
    w_gap_nxt       = r_gap;
    w_blk_valid_nxt = 1'b0;
    w_blk_addr_nxt  = o_blk_addr;
    w_blk_idx_nxt   = o_blk_idx;
    w_blk_last_nxt  = o_blk_last;
    w_free_en_nxt   = 1'b0;
    w_free_addr_nxt = o_free_addr;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_err_code_nxt  = 2'b00;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if ((i_pkt_len == '0) || (i_head_addr == '0)) begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_BADSTART;
          end else begin
            w_cur_nxt   = i_head_addr;
            w_rem_nxt   = i_pkt_len;
            w_idx_nxt   = '0;
            w_state_nxt = S_RD;
          end
        end
      end
      S_RD: w_state_nxt = S_WAIT;
      S_WAIT: begin
        w_next_nxt = i_ctrl_rdata[ADDR_W-1:0];
        if (!i_ctrl_rdata[CTRL_W-1]) begin
          w_done_nxt     = 1'b1;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_UNALLOC;
          w_state_nxt    = S_IDLE;
        end else begin
          w_blk_valid_nxt = 1'b1;
          w_blk_addr_nxt  = r_cur;
          w_blk_idx_nxt   = r_idx;
          w_blk_last_nxt  = (r_rem == LEN_W'(1));
          w_state_nxt     = S_EMIT;
        end
      end
      S_EMIT: begin
        // Payload is held in its registers until the handshake completes
        if (o_blk_valid && i_blk_ready) begin
          w_free_en_nxt   = 1'b1;
          w_free_addr_nxt = r_cur;
          w_state_nxt     = S_FREE;
        end else begin
          w_blk_valid_nxt = 1'b1;
        end
      end
      S_FREE: begin
        w_gap_nxt   = GAP_W'(FREE_GAP - 2);
        w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (r_gap != '0) begin
          w_gap_nxt = r_gap - GAP_W'(1);
        end else if (r_rem == LEN_W'(1)) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
          if (r_next != '0) begin
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_MISMATCH;
          end
        end else if (r_next == '0) begin
          // Chain ended before the advertised length
          w_done_nxt     = 1'b1;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_MISMATCH;
          w_state_nxt    = S_IDLE;
        end else begin
          w_cur_nxt   = r_next;
          w_rem_nxt   = r_rem - LEN_W'(1);
          w_idx_nxt   = r_idx + LEN_W'(1);
          w_state_nxt = S_RD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt      = (w_state_nxt != S_IDLE);
    // ctrl_addr tracks the current block whenever a packet is in flight
    w_ctrl_addr_nxt = w_busy_nxt ? w_cur_nxt : o_ctrl_addr;
  end

endmodule

// File: tb/tb_chain_reader.sv
module tb_chain_reader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned CTRL_W = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] head_addr;
  logic [LEN_W-1:0]  pkt_len;
  logic              busy;
  logic [ADDR_W-1:0] ctrl_addr;
  logic [CTRL_W-1:0] ctrl_rdata;
  logic              blk_valid, blk_ready, blk_last;
  logic [ADDR_W-1:0] blk_addr;
  logic [LEN_W-1:0]  blk_idx;
  logic              free_en;
  logic [ADDR_W-1:0] free_addr;
  logic              done, err;
  logic [1:0]        err_code;

  chain_reader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CTRL_W(CTRL_W), .FREE_GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_head_addr(head_addr), .i_pkt_len(pkt_len),
    .o_busy(busy), .o_ctrl_addr(ctrl_addr), .i_ctrl_rdata(ctrl_rdata),
    .o_blk_valid(blk_valid), .i_blk_ready(blk_ready), .o_blk_addr(blk_addr),
    .o_blk_idx(blk_idx), .o_blk_last(blk_last), .o_free_en(free_en), .o_free_addr(free_addr),
    .o_done(done), .o_err(err), .o_err_code(err_code)
  );

  always #5 clk = ~clk;

  // Ctrl memory model with one-cycle synchronous read
  logic [CTRL_W-1:0] ctrl_mem [0:1023];
  always @(posedge clk) ctrl_rdata <= ctrl_mem[ctrl_addr];

  // Monitor: records handshakes, frees and pulses as seen at each rising edge
  int acc_addr[$], acc_idx[$], acc_last[$], free_q[$], free_cyc[$];
  int cyc = 0, done_cnt = 0, err_cnt = 0, busy_with_done = 0, stab_err = 0;
  int last_code = 0;
  logic prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (prev_stall && (!blk_valid || blk_addr != prev_addr)) stab_err++;
      prev_stall = blk_valid && !blk_ready;
      prev_addr  = blk_addr;
      if (blk_valid && blk_ready) begin
        acc_addr.push_back(int'(blk_addr));
        acc_idx.push_back(int'(blk_idx));
        acc_last.push_back(int'(blk_last));
      end
      if (free_en) begin
        free_q.push_back(int'(free_addr));
        free_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        if (busy) busy_with_done++;
      end
      if (err) begin
        err_cnt++;
        last_code = int'(err_code);
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  int pass_cnt = 0, total_cnt = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [CTRL_W-1:0] ent(input logic alloc, input int nxt);
    return {alloc, ADDR_W'(nxt)};
  endfunction

  task automatic clear_mon();
    acc_addr.delete(); acc_idx.delete(); acc_last.delete();
    free_q.delete(); free_cyc.delete();
  endtask

  task automatic pulse_start(input int h, input int l);
    @(negedge clk);
    start = 1'b1; head_addr = ADDR_W'(h); pkt_len = LEN_W'(l);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_done_count"}, done_cnt - d0, 1);
  endtask

  // Compares the recorded accept/free sequence against an expected chain
  task automatic check_seq(input string tag, input int n, input int a0, input int a1, input int a2,
                           input int last_pos);
    int exp_a[3];
    exp_a[0] = a0; exp_a[1] = a1; exp_a[2] = a2;
    check({tag, "_acc_n"}, acc_addr.size(), n);
    check({tag, "_free_n"}, free_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < acc_addr.size()) begin
        check($sformatf("%s_addr%0d", tag, i), acc_addr[i], exp_a[i]);
        check($sformatf("%s_idx%0d", tag, i), acc_idx[i], i);
        check($sformatf("%s_last%0d", tag, i), acc_last[i], int'(i == last_pos));
      end
      if (i < free_q.size()) check($sformatf("%s_free%0d", tag, i), free_q[i], exp_a[i]);
      if (i > 0 && i < free_cyc.size())
        check($sformatf("%s_gap%0d", tag, i), int'(free_cyc[i] - free_cyc[i-1] >= 2), 1);
    end
  endtask

  int d0, e0;

  initial begin
    for (int i = 0; i < 1024; i++) ctrl_mem[i] = '0;
    rst_n = 1'b0; start = 1'b0; head_addr = '0; pkt_len = '0; blk_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(blk_valid), 0);
    check("rst_ctrl_addr", int'(ctrl_addr), 0);
    check("rst_free_done_err", int'({free_en, done, err, err_code}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Three-block chain 5 -> 7 -> 2, no backpressure, with latency checks
    ctrl_mem[5] = ent(1, 7); ctrl_mem[7] = ent(1, 2); ctrl_mem[2] = ent(1, 0);
    clear_mon(); d0 = done_cnt; e0 = err_cnt;
    pulse_start(5, 3);                         // start sampled at edge T
    check("t1_busy", int'(busy), 1);
    check("t1_ctrl_addr", int'(ctrl_addr), 5);
    check("t1_valid_T1", int'(blk_valid), 0);
    @(negedge clk);
    check("t1_valid_T2", int'(blk_valid), 0);
    @(negedge clk);                            // blk_valid seen high at edge T+3
    check("t1_valid_T3", int'(blk_valid), 1);
    check("t1_addr_T3", int'(blk_addr), 5);
    wait_done("t1", d0);
    check_seq("t1", 3, 5, 7, 2, 2);
    check("t1_err", err_cnt - e0, 0);
    check("t1_busy_end", int'(busy), 0);

    // Same chain with a 4-cycle stall on block 7
    clear_mon(); d0 = done_cnt; e0 = err_cnt;
    pulse_start(5, 3);
    for (int n = 0; n < 50 && !(blk_valid && blk_addr == 10'd7); n++) @(negedge clk);
    blk_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("t2_hold_valid", int'(blk_valid), 1);
    check("t2_hold_addr", int'(blk_addr), 7);
    check("t2_hold_idx", int'(blk_idx), 1);
    check("t2_no_free7", free_q.size(), 1);
    blk_ready = 1'b1;
    wait_done("t2", d0);
    check_seq("t2", 3, 5, 7, 2, 2);
    check("t2_err", err_cnt - e0, 0);
    check("t2_stable", stab_err, 0);

    // Unallocated head entry
    ctrl_mem[5] = ent(0, 7);
    clear_mon(); d0 = done_cnt; e0 = err_cnt;
    pulse_start(5, 3);
    wait_done("t3", d0);
    check("t3_err", err_cnt - e0, 1);
    check("t3_code", last_code, 1);
    check("t3_acc_n", acc_addr.size(), 0);
    check("t3_free_n", free_q.size(), 0);

    // Chain shorter than pkt_len
    ctrl_mem[5] = ent(1, 0);
    clear_mon(); d0 = done_cnt; e0 = err_cnt;
    pulse_start(5, 2);
    wait_done("t4", d0);
    check_seq("t4", 1, 5, 0, 0, -1);
    check("t4_err", err_cnt - e0, 1);
    check("t4_code", last_code, 2);

    // Chain longer than pkt_len
    ctrl_mem[5] = ent(1, 7);
    clear_mon(); d0 = done_cnt; e0 = err_cnt;
    pulse_start(5, 1);
    wait_done("t5", d0);
    check_seq("t5", 1, 5, 0, 0, 0);
    check("t5_err", err_cnt - e0, 1);
    check("t5_code", last_code, 2);

    // Bad start: zero length, then zero head
    d0 = done_cnt; e0 = err_cnt;
    pulse_start(5, 0);
    check("t6_err_len0", int'(err), 1);
    check("t6_code_len0", int'(err_code), 3);
    check("t6_busy_len0", int'(busy), 0);
    @(negedge clk);
    check("t6_err_pulse", int'(err), 0);
    pulse_start(0, 3);
    check("t6_err_head0", int'(err), 1);
    check("t6_code_head0", int'(err_code), 3);
    check("t6_busy_head0", int'(busy), 0);
    repeat (2) @(negedge clk);
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_err_count", err_cnt - e0, 2);

    // Start while busy is ignored
    ctrl_mem[5] = ent(1, 7); ctrl_mem[7] = ent(1, 2); ctrl_mem[2] = ent(1, 0);
    clear_mon(); d0 = done_cnt; e0 = err_cnt;
    pulse_start(5, 3);
    pulse_start(7, 1);
    wait_done("t7", d0);
    check_seq("t7", 3, 5, 7, 2, 2);
    check("t7_err", err_cnt - e0, 0);

    // Reset while block 7 is being presented
    clear_mon();
    pulse_start(5, 3);
    for (int n = 0; n < 50 && !(blk_valid && blk_addr == 10'd7); n++) @(negedge clk);
    blk_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t8_rst_valid", int'(blk_valid), 0);
    check("t8_rst_busy", int'(busy), 0);
    check("t8_rst_fields", int'({blk_addr, blk_idx, blk_last, ctrl_addr}), 0);
    check("t8_rst_pulses", int'({free_en, free_addr, done, err, err_code}), 0);
    @(negedge clk);
    rst_n = 1'b1; blk_ready = 1'b1;
    @(negedge clk);
    clear_mon(); d0 = done_cnt; e0 = err_cnt;
    pulse_start(5, 3);
    wait_done("t8", d0);
    check_seq("t8", 3, 5, 7, 2, 2);
    check("t8_err", err_cnt - e0, 0);
    check("busy_with_done", busy_with_done, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
